// File: rtl/mpsoc_ahb3_pkg.sv
// Shared AHB3-Lite encodings for the mpsoc initiator and its peers.
package mpsoc_ahb3_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/mpsoc_ahb3_master_port.sv
// AHB3-Lite initiator: turns a valid/ready request port into NONSEQ SINGLE
// transfers through a two-slot pipeline (address phase slot, data phase slot).
module mpsoc_ahb3_master_port
    import mpsoc_ahb3_pkg::*;
#(
    parameter int         PLEN      = 8,
    parameter int         XLEN      = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [PLEN-1:0] req_addr,
    input  logic            req_we,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam int NBYTES = XLEN / 8;

    logic            run_reg;

    logic            ap_valid_reg;
    logic [PLEN-1:0] ap_addr_reg;
    logic            ap_we_reg;
    logic [2:0]      ap_size_reg;
    logic [XLEN-1:0] ap_wdata_reg;

    logic            dp_valid_reg;
    logic            dp_we_reg;
    logic [XLEN-1:0] dp_wdata_reg;

    logic            kill_reg;

    logic            rsp_valid_reg;
    logic            rsp_err_reg;
    logic [XLEN-1:0] rsp_rdata_reg;

    logic            advance;
    logic            accept;
    logic            dp_done;
    logic            err_first;
    logic [XLEN-1:0] rsp_rdata_next;

    // kill suppresses the address phase during the second ERROR cycle so the
    // queued transfer is re-issued rather than slipping past the error.
    assign advance   = HREADY & ~kill_reg;
    assign req_ready = run_reg & (~ap_valid_reg |
                                  (HREADY & (HRESP != HRESP_ERROR) & ~kill_reg));
    assign accept    = req_valid & req_ready;
    assign dp_done   = dp_valid_reg & HREADY;
    assign err_first = dp_valid_reg & (HRESP == HRESP_ERROR) & ~HREADY;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_rdata_lane
            assign rsp_rdata_next[gi*8 +: 8] = (dp_done & ~dp_we_reg) ? HRDATA[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            run_reg       <= 1'b0;
            ap_valid_reg  <= 1'b0;
            ap_addr_reg   <= '0;
            ap_we_reg     <= 1'b0;
            ap_size_reg   <= 3'b000;
            ap_wdata_reg  <= '0;
            dp_valid_reg  <= 1'b0;
            dp_we_reg     <= 1'b0;
            dp_wdata_reg  <= '0;
            kill_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            run_reg <= 1'b1;

            if (advance) begin
                dp_valid_reg <= ap_valid_reg;
                dp_we_reg    <= ap_we_reg;
                dp_wdata_reg <= ap_wdata_reg;
            end else if (HREADY) begin
                // Second ERROR cycle: the data phase retires, ap stays put.
                dp_valid_reg <= 1'b0;
            end

            if (advance | accept) begin
                ap_valid_reg <= accept;
            end
            if (accept) begin
                ap_addr_reg  <= req_addr;
                ap_we_reg    <= req_we;
                ap_size_reg  <= req_size;
                ap_wdata_reg <= req_wdata;
            end

            kill_reg <= kill_reg ? ~HREADY : err_first;

            rsp_valid_reg <= dp_done;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= dp_done & (HRESP == HRESP_ERROR);
        end
    end

    assign HSEL      = run_reg;
    assign HADDR     = ap_addr_reg;
    assign HWRITE    = ap_we_reg;
    assign HSIZE     = ap_size_reg;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = run_reg ? HPROT_VAL : 4'b0000;
    assign HTRANS    = (ap_valid_reg & ~kill_reg) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = dp_wdata_reg;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_mpsoc_ahb3_master_port.sv
// Bench for mpsoc_ahb3_master_port: byte-array AHB slave with programmable waits
// and an error region (0xF0-0xFF), plus a byte-level memory model for expectations.
module tb_mpsoc_ahb3_master_port;
    import mpsoc_ahb3_pkg::*;

    localparam int PLEN = 8;
    localparam int XLEN = 32;
    localparam int LOGN = 4096;

    logic            HCLK = 1'b0;
    logic            HRESETn = 1'b0;
    logic            req_valid, req_ready, req_we;
    logic [PLEN-1:0] req_addr;
    logic [2:0]      req_size;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid, rsp_err;
    logic [XLEN-1:0] rsp_rdata;
    logic            HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [PLEN-1:0] HADDR;
    logic [2:0]      HSIZE, HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic [XLEN-1:0] HWDATA, HRDATA;

    always #5 HCLK = ~HCLK;

    mpsoc_ahb3_master_port #(.PLEN(PLEN), .XLEN(XLEN), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // ---------------- slave ----------------
    int          cfg_wait = 0;
    bit          rand_wait = 0;
    bit          err_en = 1;
    logic [7:0]  smem [256];
    logic        s_active, s_we, s_err, s_err2;
    logic [7:0]  s_addr;
    logic [2:0]  s_size;
    int          s_wait;

    assign HREADY = !s_active ? 1'b1 : (s_wait > 0) ? 1'b0 : (s_err && !s_err2) ? 1'b0 : 1'b1;
    assign HRESP  = s_active && (s_wait == 0) && s_err;
    assign HRDATA = {smem[{s_addr[7:2], 2'b11}], smem[{s_addr[7:2], 2'b10}],
                     smem[{s_addr[7:2], 2'b01}], smem[{s_addr[7:2], 2'b00}]};

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_active <= 1'b0; s_we <= 1'b0; s_err <= 1'b0; s_err2 <= 1'b0;
            s_addr <= 8'h00; s_size <= 3'b000; s_wait <= 0;
            for (int i = 0; i < 256; i++) smem[i] <= 8'h00;
        end else if (HREADY) begin
            if (s_active && s_we && !s_err) begin
                for (int k = 0; k < 4; k++)
                    if (k < (1 << s_size))
                        smem[8'(int'(s_addr) + k)] <= HWDATA[8*((int'(s_addr) + k) % 4) +: 8];
            end
            s_active <= HSEL && (HTRANS == HTRANS_NONSEQ);
            s_addr   <= HADDR;
            s_we     <= HWRITE;
            s_size   <= HSIZE;
            s_wait   <= rand_wait ? int'($urandom_range(0, 3)) : cfg_wait;
            s_err    <= err_en && (HADDR[7:4] == 4'hF);
            s_err2   <= 1'b0;
        end else begin
            if (s_wait > 0) s_wait <= s_wait - 1;
            else if (s_err) s_err2 <= 1'b1;
        end
    end

    // ---------------- monitor / logs ----------------
    typedef struct { logic [31:0] rdata; logic err; int cyc; } got_t;
    typedef struct { logic [31:0] rdata; logic err; int acc; int lat; } exp_t;
    typedef struct { logic we; logic [7:0] addr; logic [2:0] size; logic [31:0] wdata;
                     logic [31:0] rdata; logic err; int lat; } vec_t;

    got_t       got_q[$];
    exp_t       sb[$];
    int         cyc = 0;
    logic [1:0] log_htrans [LOGN];
    logic [7:0] log_haddr  [LOGN];
    logic       log_hwrite [LOGN];
    logic [2:0] log_hsize  [LOGN];
    logic       log_rdy    [LOGN];
    logic [31:0] log_hwdata [LOGN];

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (cyc < LOGN) begin
            log_htrans[cyc] <= HTRANS;
            log_haddr[cyc]  <= HADDR;
            log_hwrite[cyc] <= HWRITE;
            log_hsize[cyc]  <= HSIZE;
            log_rdy[cyc]    <= req_ready;
            log_hwdata[cyc] <= HWDATA;
        end
        if (HRESETn && rsp_valid)
            got_q.push_back(got_t'{rdata: rsp_rdata, err: rsp_err, cyc: cyc});
    end

    // ---------------- reference model ----------------
    logic [7:0] mmem [256];
    int checks = 0;
    int failures = 0;

    function automatic logic m_err(input logic [7:0] a);
        return err_en && (a[7:4] == 4'hF);
    endfunction

    function automatic logic [31:0] m_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {mmem[b + 8'd3], mmem[b + 8'd2], mmem[b + 8'd1], mmem[b]};
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [2:0] size, input logic [31:0] wd);
        logic [7:0] idx;
        for (int k = 0; k < (1 << size); k++) begin
            idx = a + 8'(k);
            mmem[idx] = wd[8*idx[1:0] +: 8];
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic we, input logic [7:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input int lat, input bit use_exp,
                         input logic [31:0] x_rdata, input logic x_err, output int acc_cyc);
        exp_t e;
        bit   acc;
        int   n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
        acc = 0; n = 0; acc_cyc = -1;
        while (!acc && n < 100) begin
            @(negedge HCLK);
            acc = req_ready;
            if (acc) acc_cyc = cyc;
            @(posedge HCLK);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL accept addr=%h got=timeout want=req_ready", addr);
        end else begin
            e.err   = use_exp ? x_err : m_err(addr);
            e.rdata = use_exp ? x_rdata : (we ? 32'h0 : m_word(addr));
            e.acc   = acc_cyc;
            e.lat   = lat;
            sb.push_back(e);
            if (we && !m_err(addr)) m_write(addr, size, wdata);
        end
    endtask

    task automatic check_responses(input string name);
        exp_t e;
        got_t g;
        int   n = 0;
        while (got_q.size() < sb.size() && n < 300) begin
            @(posedge HCLK); #1; n++;
        end
        wait_cycles(4);
        chk({name, "_rsp_count"}, got_q.size(), sb.size());
        while (sb.size() > 0 && got_q.size() > 0) begin
            e = sb.pop_front();
            g = got_q.pop_front();
            $display("txn %s rdata=%h err=%b cyc=%0d", name, g.rdata, g.err, g.cyc);
            chk({name, "_rdata"}, g.rdata, e.rdata);
            chk({name, "_err"}, {31'h0, g.err}, {31'h0, e.err});
            if (e.lat >= 0) chk({name, "_latency"}, g.cyc - e.acc, e.lat);
        end
        sb.delete();
        got_q.delete();
    endtask

    vec_t tbl [7];
    int   acc [7];
    int   a0, a1;

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        tbl[0] = vec_t'{1'b1, 8'h10, HSIZE_WORD, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0, 3};
        tbl[1] = vec_t'{1'b0, 8'h10, HSIZE_WORD, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0, 3};
        tbl[2] = vec_t'{1'b1, 8'h03, HSIZE_BYTE, 32'h7E00_0000, 32'h0000_0000, 1'b0, 3};
        tbl[3] = vec_t'{1'b0, 8'h00, HSIZE_WORD, 32'h0000_0000, 32'h7E00_0000, 1'b0, 3};
        tbl[4] = vec_t'{1'b1, 8'h04, HSIZE_WORD, 32'h1234_5678, 32'h0000_0000, 1'b0, 3};
        tbl[5] = vec_t'{1'b1, 8'hFC, HSIZE_WORD, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 4};
        tbl[6] = vec_t'{1'b0, 8'h04, HSIZE_WORD, 32'h0000_0000, 32'h1234_5678, 1'b0, 5};
        m_clear();

        // reset state
        #12;
        chk("reset_htrans", HTRANS, HTRANS_IDLE);
        chk("reset_hsel", HSEL, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_hprot", HPROT, 0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        wait_cycles(2);
        chk("run_req_ready", req_ready, 1);
        chk("run_hsel", HSEL, 1);
        chk("run_hburst", HBURST, HBURST_SINGLE);

        // table: write/read, byte lane, ERROR with read queued behind it
        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wdata, tbl[i].lat, 1'b1,
                  tbl[i].rdata, tbl[i].err, acc[i]);
        end
        check_responses("table");
        if (acc[0] >= 0 && acc[0] + 2 < LOGN) begin
            chk("t1_htrans_w", log_htrans[acc[0]+1], HTRANS_NONSEQ);
            chk("t1_hwrite_w", log_hwrite[acc[0]+1], 1);
            chk("t1_haddr_w", log_haddr[acc[0]+1], 8'h10);
            chk("t1_htrans_r", log_htrans[acc[0]+2], HTRANS_NONSEQ);
            chk("t1_hwrite_r", log_hwrite[acc[0]+2], 0);
        end
        if (acc[2] >= 0 && acc[2] + 1 < LOGN) begin
            chk("t4_hsize", log_hsize[acc[2]+1], HSIZE_BYTE);
            chk("t4_haddr", log_haddr[acc[2]+1], 8'h03);
        end
        if (acc[5] >= 0 && acc[5] + 4 < LOGN) begin
            chk("t3_idle_2nd_err", log_htrans[acc[5]+3], HTRANS_IDLE);
            chk("t3_reissue", log_htrans[acc[5]+4], HTRANS_NONSEQ);
            chk("t3_reissue_addr", log_haddr[acc[5]+4], 8'h04);
        end

        // three wait states on a read data phase, second read held in ap
        cfg_wait = 3;
        issue(1'b0, 8'h10, HSIZE_WORD, 32'h0, 6, 1'b0, 32'h0, 1'b0, a0);
        issue(1'b0, 8'h14, HSIZE_WORD, 32'h0, 9, 1'b0, 32'h0, 1'b0, a1);
        check_responses("wait");
        chk("t2_accept_gap", a1 - a0, 1);
        if (a0 >= 0 && a0 + 4 < LOGN) begin
            for (int k = 2; k <= 4; k++) begin
                chk("t2_req_ready", log_rdy[a0+k], 0);
                chk("t2_haddr", log_haddr[a0+k], 8'h14);
                chk("t2_htrans", log_htrans[a0+k], HTRANS_NONSEQ);
                chk("t2_hwdata", log_hwdata[a0+k], log_hwdata[a0+2]);
            end
        end

        // reset with two transfers outstanding
        issue(1'b0, 8'h10, HSIZE_WORD, 32'h0, -1, 1'b0, 32'h0, 1'b0, a0);
        issue(1'b0, 8'h14, HSIZE_WORD, 32'h0, -1, 1'b0, 32'h0, 1'b0, a1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("t5_htrans", HTRANS, HTRANS_IDLE);
        chk("t5_hsel", HSEL, 0);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_haddr", HADDR, 0);
        chk("t5_hwrite", HWRITE, 0);
        chk("t5_hsize", HSIZE, 0);
        chk("t5_hprot", HPROT, 0);
        chk("t5_hwdata", HWDATA, 0);
        chk("t5_hmastlock", HMASTLOCK, 0);
        sb.delete();
        got_q.delete();
        m_clear();
        cfg_wait = 0;
        wait_cycles(3);
        HRESETn = 1'b1;
        wait_cycles(6);
        chk("t5_no_rsp", got_q.size(), 0);
        chk("t5_req_ready_after", req_ready, 1);
        chk("t5_hprot_after", HPROT, 4'b0011);
        issue(1'b1, 8'h20, HSIZE_WORD, 32'hDEAD_BEEF, 3, 1'b0, 32'h0, 1'b0, a0);
        issue(1'b0, 8'h20, HSIZE_WORD, 32'h0, 3, 1'b0, 32'h0, 1'b0, a1);
        check_responses("post_reset");

        // random back-to-back traffic with random waits and errors
        rand_wait = 1;
        for (int i = 0; i < 16; i++) begin
            logic       we;
            logic [2:0] sz;
            logic [7:0] ad;
            we = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 2));
            ad = {($urandom_range(0, 3) == 0) ? 4'hF : 4'h1, 4'($urandom_range(0, 15))};
            ad = ad & ~8'((1 << sz) - 1);
            issue(we, ad, sz, $urandom, -1, 1'b0, 32'h0, 1'b0, a0);
        end
        check_responses("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
